// File: rtl/gamepad_poller.sv
// gamepad_poller
// Serial gamepad scanner. Drives shared latch/clock strobes to NUM_PADS
// shift-register controllers, shifts in PAD_BITS buttons from every pad in
// parallel and publishes an active-high button word with a one-cycle Valid.
//
// Parameters: NUM_PADS (pads), PAD_BITS (buttons per pad, >=1),
//             CLK_DIV (system cycles per strobe phase, >=1)
// Ports:
//   Clock        system clock, rising edge
//   Reset        synchronous active-low reset
//   Poll         scan request, only looked at in IDLE
//   GamePadData  serial data per pad, active-low
//   PadLatch     latch strobe to all pads
//   PadClock     shift clock to all pads
//   Buttons      last completed scan, pad p at [p*PAD_BITS +: PAD_BITS]
//   Valid        one-cycle pulse when Buttons updates
//   Busy         high whenever not IDLE
//   Pressed      newly pressed buttons of the last scan
//                (only when GAMEPAD_EDGE_DETECT_EN is defined)
module gamepad_poller #(
  parameter int NUM_PADS = 2,
  parameter int PAD_BITS = 8,
  parameter int CLK_DIV  = 300
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Poll,
  input  logic [NUM_PADS-1:0]          GamePadData,
  output logic                         PadLatch,
  output logic                         PadClock,
  output logic [NUM_PADS*PAD_BITS-1:0] Buttons,
  output logic                         Valid,
  output logic                         Busy
`ifdef GAMEPAD_EDGE_DETECT_EN
  ,
  output logic [NUM_PADS*PAD_BITS-1:0] Pressed
`endif
);

  localparam int W  = NUM_PADS * PAD_BITS;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int KW = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, PULSE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [W-1:0]  shift;
  logic [W-1:0]  shift_nxt;
  logic          last;
  logic          last_bit;

  assign last     = (cnt == CW'(CLK_DIV - 1));
  assign last_bit = (k == KW'(PAD_BITS - 1));

  // Shift register with the current bit of every pad dropped in; used both
  // as the capture value and as the Buttons load value on the final bit.
  always_comb begin
    shift_nxt = shift;
    for (int p = 0; p < NUM_PADS; p++)
      shift_nxt[p*PAD_BITS + int'(k)] = ~GamePadData[p];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      shift    <= '0;
      PadLatch <= 1'b0;
      PadClock <= 1'b0;
      Buttons  <= '0;
      Valid    <= 1'b0;
      Busy     <= 1'b0;
`ifdef GAMEPAD_EDGE_DETECT_EN
      Pressed  <= '0;
`endif
    end else begin
      Valid <= 1'b0;
      cnt   <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (Poll) begin
            state    <= LATCH;
            k        <= '0;
            shift    <= '0;
            PadLatch <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        LATCH: if (last) begin
          state    <= SAMPLE;
          cnt      <= '0;
          PadLatch <= 1'b0;
        end
        SAMPLE: if (last) begin
          cnt   <= '0;
          shift <= shift_nxt;
          if (last_bit) begin
            state   <= DONE;
            Buttons <= shift_nxt;
            Valid   <= 1'b1;
`ifdef GAMEPAD_EDGE_DETECT_EN
            // Buttons still holds the previous scan here, so it is the old copy.
            Pressed <= shift_nxt & ~Buttons;
`endif
          end else begin
            state    <= PULSE;
            PadClock <= 1'b1;
          end
        end
        PULSE: if (last) begin
          state    <= SAMPLE;
          cnt      <= '0;
          k        <= k + 1'b1;
          PadClock <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
          Busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          PadLatch <= 1'b0;
          PadClock <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_poller.sv
module tb_gamepad_poller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Poll  = 1'b0;
  logic [1:0]  GamePadData;
  logic        PadLatch, PadClock, Valid, Busy;
  logic [15:0] Buttons;
`ifdef GAMEPAD_EDGE_DETECT_EN
  logic [15:0] Pressed;
`endif

  int checks = 0;
  int failures = 0;

  gamepad_poller #(.NUM_PADS(2), .PAD_BITS(8), .CLK_DIV(2)) dut (
    .Clock(Clock), .Reset(Reset), .Poll(Poll), .GamePadData(GamePadData),
    .PadLatch(PadLatch), .PadClock(PadClock), .Buttons(Buttons),
    .Valid(Valid), .Busy(Busy)
`ifdef GAMEPAD_EDGE_DETECT_EN
    , .Pressed(Pressed)
`endif
  );

  always #5 Clock = ~Clock;

  // Pad model: parallel load while latched, shift LSB-first on PadClock rise,
  // lines are active-low.
  logic [7:0] pad_val [2];
  logic [7:0] psr [2];
  logic       pclk_q = 1'b0;
  always @(posedge Clock) begin
    pclk_q <= PadClock;
    for (int p = 0; p < 2; p++) begin
      if (PadLatch) psr[p] <= ~pad_val[p];
      else if (PadClock && !pclk_q) psr[p] <= {1'b1, psr[p][7:1]};
    end
  end
  assign GamePadData = {psr[1][0], psr[0][0]};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one scan (Poll high in cycle 0) and observe cycles 1..60.
  // poll_at != 0 re-raises Poll for one cycle mid-scan.
  task automatic run_scan(input int poll_at, output int vcyc, output int nvalid,
                          output int lat_first, output int lat_last,
                          output int nrise, output int nhi, output logic [15:0] btn);
    logic prev;
    vcyc = -1; nvalid = 0; lat_first = -1; lat_last = -1; nrise = 0; nhi = 0;
    btn = 16'h0; prev = 1'b0;
    @(negedge Clock); Poll = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clock);
      Poll = (c == poll_at);
      if (PadLatch) begin
        if (lat_first < 0) lat_first = c;
        lat_last = c;
      end
      if (PadClock) nhi++;
      if (PadClock && !prev) nrise++;
      prev = PadClock;
      if (Valid) begin
        nvalid++;
        if (vcyc < 0) begin vcyc = c; btn = Buttons; end
      end
    end
    Poll = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int vc, nv, lf, ll, nr, nh, v1, v2, low;
    logic [15:0] b;

    vecs[0] = '{8'hA5, 8'h00, 16'h00A5};
    vecs[1] = '{8'h01, 8'h80, 16'h8001};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    vecs[3] = '{8'h00, 8'h00, 16'h0000};
    vecs[4] = '{8'h3C, 8'hC3, 16'hC33C};
    pad_val[0] = 8'h00; pad_val[1] = 8'h00;

    repeat (3) @(negedge Clock);
    chk("reset_latch",   int'(PadLatch), 0);
    chk("reset_clock",   int'(PadClock), 0);
    chk("reset_busy",    int'(Busy), 0);
    chk("reset_valid",   int'(Valid), 0);
    chk("reset_buttons", int'(Buttons), 0);
    Reset = 1'b1;
    @(negedge Clock);

    // Table-driven scans
    for (int i = 0; i < 5; i++) begin
      pad_val[0] = vecs[i].p0; pad_val[1] = vecs[i].p1;
      run_scan(0, vc, nv, lf, ll, nr, nh, b);
      chk($sformatf("v%0d_buttons", i), int'(b), int'(vecs[i].exp));
      chk($sformatf("v%0d_valid_cycle", i), vc, 33);
      chk($sformatf("v%0d_valid_count", i), nv, 1);
      chk($sformatf("v%0d_latch_first", i), lf, 1);
      chk($sformatf("v%0d_latch_last", i), ll, 2);
      chk($sformatf("v%0d_pulses", i), nr, 7);
      chk($sformatf("v%0d_pclk_hi", i), nh, 14);
      chk($sformatf("v%0d_hold", i), int'(Buttons), int'(vecs[i].exp));
      chk($sformatf("v%0d_idle", i), int'(Busy), 0);
    end

    // Poll pulsed mid-scan is ignored
    pad_val[0] = 8'h5A; pad_val[1] = 8'h11;
    run_scan(10, vc, nv, lf, ll, nr, nh, b);
    chk("ignore_valid_count", nv, 1);
    chk("ignore_buttons", int'(b), 16'h115A);

    // Poll held high: back-to-back scans with one IDLE cycle between
    v1 = -1; v2 = -1; low = 0;
    @(negedge Clock); Poll = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge Clock);
      if (Valid) begin
        if (v1 < 0) v1 = c;
        else if (v2 < 0) v2 = c;
      end
      if (v1 > 0 && v2 < 0 && !Busy) low++;
    end
    Poll = 1'b0;
    repeat (40) @(negedge Clock);
    chk("held_first_valid", v1, 33);
    chk("held_second_valid", v2, 67);
    chk("held_busy_low", low, 1);

    // Reset during PULSE (cycles 5-6), then a clean scan
    pad_val[0] = 8'hFF; pad_val[1] = 8'hFF;
    @(negedge Clock); Poll = 1'b1;
    @(negedge Clock); Poll = 1'b0;        // cycle 1
    repeat (4) @(negedge Clock);          // cycle 5
    chk("mid_in_pulse", int'(PadClock), 1);
    Reset = 1'b0;
    @(negedge Clock);
    chk("mid_rst_latch",   int'(PadLatch), 0);
    chk("mid_rst_clock",   int'(PadClock), 0);
    chk("mid_rst_busy",    int'(Busy), 0);
    chk("mid_rst_valid",   int'(Valid), 0);
    chk("mid_rst_buttons", int'(Buttons), 0);
    Reset = 1'b1;
    pad_val[0] = 8'h96; pad_val[1] = 8'h0F;
    run_scan(0, vc, nv, lf, ll, nr, nh, b);
    chk("post_rst_buttons", int'(b), 16'h0F96);
    chk("post_rst_valid_cycle", vc, 33);
    chk("post_rst_pulses", nr, 7);

`ifdef GAMEPAD_EDGE_DETECT_EN
    @(negedge Clock); Reset = 1'b0;
    @(negedge Clock); Reset = 1'b1;
    chk("edge_rst_pressed", int'(Pressed), 0);
    pad_val[0] = 8'h03; pad_val[1] = 8'h00;
    run_scan(0, vc, nv, lf, ll, nr, nh, b);
    chk("edge_first", int'(Pressed), 16'h0003);
    pad_val[0] = 8'h06;
    run_scan(0, vc, nv, lf, ll, nr, nh, b);
    chk("edge_second", int'(Pressed), 16'h0004);
    chk("edge_buttons", int'(Buttons), 16'h0006);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
